multi_cycle_ctr: RTL

//  Multi-cycle MIPS control FSM; sequences shared-memory datapath (PC, IR, A/B, ALUOut, MDR).

---
 rtl/multi_cycle_ctr.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_ctr.sv
// multi_cycle_ctr: control FSM for a multi-cycle MIPS datapath with a shared
// instruction/data memory. Sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and write enables, and counts retired instructions.
// Moore control bits are registered from the next-state decode so they come
// straight off flops; only the FETCH pcWrite/irWrite follow memReady directly.
module multi_cycle_ctr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opCode,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic             iorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             memToReg,
    output logic             regDst,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [1:0]       pcSource,
    output logic             illegalOp,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instrCnt
);

    localparam logic [3:0] S_RST    = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MADDR  = 4'd3;
    localparam logic [3:0] S_MREAD  = 4'd4;
    localparam logic [3:0] S_MWB    = 4'd5;
    localparam logic [3:0] S_MWRITE = 4'd6;
    localparam logic [3:0] S_REXE   = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_BR     = 4'd9;
    localparam logic [3:0] S_JMP    = 4'd10;
    localparam logic [3:0] S_AEXE   = 4'd11;
    localparam logic [3:0] S_AWB    = 4'd12;
    localparam logic [3:0] S_ILL    = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // fetch marks the FETCH state so pcWrite/irWrite can follow memReady.
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       illegalOp;
        logic       fetch;
    } ctrl_t;

    // Moore control decode; unlisted bits and unused codes (14/15) stay 0.
    function automatic ctrl_t ctrlFor(input logic [3:0] st);
        ctrl_t c;
        c = ctrl_t'(17'h00000);
        case (st)
            S_FETCH: begin
                c.memRead = 1'b1;
                c.aluSrcB = 2'b01;
                c.fetch   = 1'b1;
            end
            S_DECODE: begin
                c.aluSrcB = 2'b11;
            end
            S_MADDR, S_AEXE: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
            end
            S_MREAD: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            S_MWB: begin
                c.regWrite = 1'b1;
                c.memToReg = 1'b1;
            end
            S_MWRITE: begin
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            S_REXE: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = 2'b10;
            end
            S_RWB: begin
                c.regWrite = 1'b1;
                c.regDst   = 1'b1;
            end
            S_AWB: begin
                c.regWrite = 1'b1;
            end
            S_BR: begin
                c.aluSrcA     = 1'b1;
                c.aluOp       = 2'b01;
                c.pcWriteCond = 1'b1;
                c.pcSource    = 2'b01;
            end
            S_JMP: begin
                c.pcWrite  = 1'b1;
                c.pcSource = 2'b10;
            end
            S_ILL: begin
                c.illegalOp = 1'b1;
            end
            default: begin
                c = ctrl_t'(17'h00000);
            end
        endcase
        return c;
    endfunction

    logic [3:0]       state_r;
    logic [3:0]       nextState_s;
    ctrl_t            ctrl_r;
    logic [CNT_W-1:0] cnt_r;
    logic             retire_s;

    // Next-state selection, including memory wait loops and opcode dispatch.
    always_comb begin
        nextState_s = S_FETCH;
        case (state_r)
            S_RST:    nextState_s = S_FETCH;
            S_FETCH: begin
                if (memReady) begin
                    nextState_s = S_DECODE;
                end else begin
                    nextState_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opCode)
                    OP_LW, OP_SW: nextState_s = S_MADDR;
                    OP_RTYPE:     nextState_s = S_REXE;
                    OP_BEQ:       nextState_s = S_BR;
                    OP_J:         nextState_s = S_JMP;
                    OP_ADDI:      nextState_s = S_AEXE;
                    default:      nextState_s = S_ILL;
                endcase
            end
            S_MADDR: begin
                // Opcode is looked at again here; anything that is no longer a
                // load or store is treated as illegal rather than guessed at.
                if (opCode == OP_LW) begin
                    nextState_s = S_MREAD;
                end else if (opCode == OP_SW) begin
                    nextState_s = S_MWRITE;
                end else begin
                    nextState_s = S_ILL;
                end
            end
            S_MREAD: begin
                if (memReady) begin
                    nextState_s = S_MWB;
                end else begin
                    nextState_s = S_MREAD;
                end
            end
            S_MWRITE: begin
                if (memReady) begin
                    nextState_s = S_FETCH;
                end else begin
                    nextState_s = S_MWRITE;
                end
            end
            S_REXE:   nextState_s = S_RWB;
            S_AEXE:   nextState_s = S_AWB;
            S_MWB, S_RWB, S_AWB, S_BR, S_JMP, S_ILL: nextState_s = S_FETCH;
            default:  nextState_s = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            S_MWB, S_RWB, S_AWB, S_BR, S_JMP: retire_s = 1'b1;
            S_MWRITE:                         retire_s = memReady;
            default:                          retire_s = 1'b0;
        endcase
    end

    // State, registered control bits and retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_RST;
            ctrl_r  <= ctrl_t'(17'h00000);
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= nextState_s;
            ctrl_r  <= ctrlFor(nextState_s);
            if (retire_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign pcWrite     = ctrl_r.pcWrite | (ctrl_r.fetch & memReady);
    assign irWrite     = ctrl_r.fetch & memReady;
    assign pcWriteCond = ctrl_r.pcWriteCond;
    assign iorD        = ctrl_r.iorD;
    assign memRead     = ctrl_r.memRead;
    assign memWrite    = ctrl_r.memWrite;
    assign memToReg    = ctrl_r.memToReg;
    assign regDst      = ctrl_r.regDst;
    assign regWrite    = ctrl_r.regWrite;
    assign aluSrcA     = ctrl_r.aluSrcA;
    assign aluSrcB     = ctrl_r.aluSrcB;
    assign aluOp       = ctrl_r.aluOp;
    assign pcSource    = ctrl_r.pcSource;
    assign illegalOp   = ctrl_r.illegalOp;
    assign state       = state_r;
    assign instrCnt    = cnt_r;

endmodule
